// File: rtl/peripheral_timer_scheduler_ahb4.sv
// AHB4-Lite master that programs the peripheral timer and, on every tint,
// re-arms each pending channel with its own 64-bit deadline += period.
module peripheral_timer_scheduler_ahb4 #(
  parameter int                    HADDR_SIZE = 32,
  parameter int                    HDATA_SIZE = 32,
  parameter int                    TIMERS     = 3,
  parameter logic [HADDR_SIZE-1:0] BASE       = '0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  start,
  input  logic [31:0]           prescale,
  input  logic [TIMERS*32-1:0]  period,
  input  logic [TIMERS-1:0]     chan_en,
  input  logic                  tint,
  output logic [TIMERS-1:0]     tick,
  output logic                  busy,
  output logic                  error,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int CW = (TIMERS > 1) ? $clog2(TIMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_PRE, S_INIT_CMP, S_INIT_IEN,
    S_WAIT_INT, S_RD_PEND, S_SVC, S_ERR
  } state_e;

  typedef enum logic {PH_ADDR, PH_DATA} phase_e;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [CW-1:0]        chan_q, chan_d;
  logic                 lo_q, lo_d;
  logic [31:0]          prescale_q, prescale_d;
  logic [TIMERS*32-1:0] period_q, period_d;
  logic [TIMERS-1:0]    chanEn_q, chanEn_d;
  logic [TIMERS-1:0]    pend_q, pend_d;
  logic [63:0]          deadline_q [TIMERS];
  logic [63:0]          deadline_d [TIMERS];
  logic                 error_q, error_d;
  logic [TIMERS-1:0]    tick_q, tick_d;

  logic                  firstEnFound, nextEnFound;
  logic [CW-1:0]         firstEnIdx, nextEnIdx, pendIdx;
  logic [TIMERS-1:0]     perNz;
  logic [31:0]           svcPeriod;
  logic [63:0]           svcNewDl, cmpDl;
  logic                  xferActive, xferDone, addrPhase, curWrite;
  logic [HADDR_SIZE-1:0] curAddr;
  logic [31:0]           curWdata;
  logic                  unused_hrdata;

  assign unused_hrdata = ^HRDATA[HDATA_SIZE-1:TIMERS];

  function automatic logic [HADDR_SIZE-1:0] cmpAddr(input logic [CW-1:0] ch, input logic lo);
    cmpAddr = BASE + HADDR_SIZE'(32'h1C) + (HADDR_SIZE'(ch) << 4) - (lo ? HADDR_SIZE'(4) : '0);
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_ADDR;
      chan_q     <= '0;
      lo_q       <= 1'b0;
      prescale_q <= '0;
      period_q   <= '0;
      chanEn_q   <= '0;
      pend_q     <= '0;
      error_q    <= 1'b0;
      tick_q     <= '0;
      for (int n = 0; n < TIMERS; n++) deadline_q[n] <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      chan_q     <= chan_d;
      lo_q       <= lo_d;
      prescale_q <= prescale_d;
      period_q   <= period_d;
      chanEn_q   <= chanEn_d;
      pend_q     <= pend_d;
      error_q    <= error_d;
      tick_q     <= tick_d;
      deadline_q <= deadline_d;
    end
  end

  // Descending scans so the lowest matching channel wins.
  always_comb begin
    firstEnFound = 1'b0;
    firstEnIdx   = '0;
    nextEnFound  = 1'b0;
    nextEnIdx    = '0;
    pendIdx      = '0;
    perNz        = '0;
    for (int n = TIMERS - 1; n >= 0; n--) begin
      perNz[n] = |period_q[n*32 +: 32];
      if (chanEn_q[n]) begin
        firstEnFound = 1'b1;
        firstEnIdx   = CW'(n);
      end
      if (chanEn_q[n] && (CW'(n) > chan_q)) begin
        nextEnFound = 1'b1;
        nextEnIdx   = CW'(n);
      end
      if (pend_q[n]) pendIdx = CW'(n);
    end
  end

  assign svcPeriod = period_q[pendIdx*32 +: 32];
  assign svcNewDl  = deadline_q[pendIdx] + {32'h0, svcPeriod};
  assign cmpDl     = deadline_q[chan_q];

  // Address/data of the transfer owned by the current state; stable for its whole duration.
  always_comb begin
    xferActive = 1'b0;
    curWrite   = 1'b1;
    curAddr    = '0;
    curWdata   = '0;
    case (state_q)
      S_INIT_PRE: begin
        xferActive = 1'b1;
        curAddr    = BASE;
        curWdata   = prescale_q;
      end
      S_INIT_CMP: begin
        xferActive = 1'b1;
        curAddr    = cmpAddr(chan_q, lo_q);
        curWdata   = lo_q ? cmpDl[31:0] : cmpDl[63:32];
      end
      S_INIT_IEN: begin
        xferActive = 1'b1;
        curAddr    = BASE + HADDR_SIZE'(32'hC);
        curWdata   = 32'(chanEn_q);
      end
      S_RD_PEND: begin
        xferActive = 1'b1;
        curWrite   = 1'b0;
        curAddr    = BASE + HADDR_SIZE'(32'h8);
      end
      S_SVC: begin
        xferActive = |pend_q;
        curAddr    = cmpAddr(pendIdx, lo_q);
        curWdata   = lo_q ? svcNewDl[31:0] : svcNewDl[63:32];
      end
      default: ;
    endcase
  end

  assign xferDone  = xferActive && (phase_q == PH_DATA) && HREADY;
  assign addrPhase = xferActive && (phase_q == PH_ADDR);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    chan_d     = chan_q;
    lo_d       = lo_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    chanEn_d   = chanEn_q;
    pend_d     = pend_q;
    deadline_d = deadline_q;
    error_d    = error_q;
    tick_d     = '0;
    if (xferActive && HREADY) phase_d = (phase_q == PH_ADDR) ? PH_DATA : PH_ADDR;
    if (xferDone && HRESP) begin
      state_d = S_ERR;
      error_d = 1'b1;
      phase_d = PH_ADDR;
      lo_d    = 1'b0;
      pend_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR, S_WAIT_INT: begin
          if (start) begin
            state_d    = S_INIT_PRE;
            phase_d    = PH_ADDR;
            lo_d       = 1'b0;
            pend_d     = '0;
            error_d    = 1'b0;
            prescale_d = prescale;
            period_d   = period;
            chanEn_d   = chan_en;
            for (int n = 0; n < TIMERS; n++)
              if (chan_en[n]) deadline_d[n] = {32'h0, period[n*32 +: 32]};
          end else if (state_q == S_WAIT_INT && tint) begin
            state_d = S_RD_PEND;
          end
        end
        S_INIT_PRE: if (xferDone) begin
          lo_d = 1'b0;
          if (firstEnFound) begin
            state_d = S_INIT_CMP;
            chan_d  = firstEnIdx;
          end else begin
            state_d = S_INIT_IEN;
          end
        end
        S_INIT_CMP: if (xferDone) begin
          lo_d = !lo_q;
          if (lo_q) begin
            if (nextEnFound) chan_d = nextEnIdx;
            else             state_d = S_INIT_IEN;
          end
        end
        S_INIT_IEN: if (xferDone) state_d = S_WAIT_INT;
        S_RD_PEND: if (xferDone) begin
          pend_d  = HRDATA[TIMERS-1:0] & chanEn_q & perNz;
          lo_d    = 1'b0;
          state_d = S_SVC;
        end
        S_SVC: begin
          if (pend_q == '0) begin
            state_d = S_WAIT_INT;
          end else if (xferDone) begin
            lo_d = !lo_q;
            if (lo_q) begin
              deadline_d[pendIdx] = svcNewDl;
              pend_d[pendIdx]     = 1'b0;
              tick_d[pendIdx]     = 1'b1;
              if ((pend_q & ~(TIMERS'(1) << pendIdx)) == '0) state_d = S_WAIT_INT;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign HSEL   = addrPhase;
  assign HTRANS = addrPhase ? 2'b10 : 2'b00;
  assign HADDR  = addrPhase ? curAddr : '0;
  assign HWRITE = addrPhase && curWrite;
  assign HWDATA = (xferActive && phase_q == PH_DATA && curWrite) ? HDATA_SIZE'(curWdata) : '0;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign tick   = tick_q;
  assign error  = error_q;
  assign busy   = !(state_q == S_IDLE || state_q == S_WAIT_INT || state_q == S_ERR);

endmodule

// File: tb/tb_peripheral_timer_scheduler_ahb4.sv
// Scoreboard bench: stimulus pushes expected transfers/ticks, a negedge
// monitor pops and compares them as the DUT presents them on the bus.
module tb_peripheral_timer_scheduler_ahb4;

  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_TICK = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  tickv;
  } exp_t;

  logic        HRESETn, HCLK, start, tint, HREADY, HRESP;
  logic [31:0] prescale, HRDATA, HADDR, HWDATA;
  logic [95:0] period;
  logic [2:0]  chan_en, tick, HSIZE, HBURST;
  logic        busy, error, HSEL, HWRITE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  exp_t        expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        dataPending = 1'b0;
  logic [31:0] latAddr;
  logic        latWr;

  peripheral_timer_scheduler_ahb4 #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .TIMERS(3), .BASE(32'h0)
  ) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .start(start), .prescale(prescale),
    .period(period), .chan_en(chan_en), .tint(tint), .tick(tick),
    .busy(busy), .error(error), .HSEL(HSEL), .HADDR(HADDR),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic flagTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  task automatic expectWr(input logic [31:0] a, input logic [31:0] d);
    expQ.push_back('{kind: K_WR, addr: a, data: d, tickv: 3'b000});
  endtask

  task automatic expectRd(input logic [31:0] a);
    expQ.push_back('{kind: K_RD, addr: a, data: 32'h0, tickv: 3'b000});
  endtask

  task automatic expectTick(input logic [2:0] m);
    expQ.push_back('{kind: K_TICK, addr: 32'h0, data: 32'h0, tickv: m});
  endtask

  task automatic tickCycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pre, input logic [95:0] per, input logic [2:0] en);
    prescale = pre;
    period   = per;
    chan_en  = en;
    start    = 1'b1;
    tickCycle();
    start    = 1'b0;
  endtask

  task automatic pulseTint(input logic [31:0] pending);
    HRDATA = pending;
    tint   = 1'b1;
    tickCycle();
    tint   = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < budget) begin
      tickCycle();
      n++;
    end
    checkOutput({name, " queue"}, 64'(expQ.size()), 64'd0);
    checkOutput({name, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic waitAddr(input logic [31:0] a, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (HTRANS == 2'b10 && HADDR == a && HWRITE) begin
        ok = 1'b1;
        break;
      end
      tickCycle();
    end
    if (!ok) flagTimeout(name);
  endtask

  // Monitor: ticks, then transfer completions, then address/data phase values.
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      dataPending = 1'b0;
    end else begin
      if (tick !== 3'b000) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected tick", 64'(tick), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("tick", 64'(tick), (e.kind == K_TICK) ? 64'(e.tickv) : 64'd0);
        end
      end
      if (dataPending && HREADY) begin
        e = expQ.pop_front();
        checkOutput("xfer kind", latWr ? 64'(K_WR) : 64'(K_RD), 64'(e.kind));
        checkOutput("xfer addr", 64'(latAddr), 64'(e.addr));
        if (latWr) checkOutput("xfer wdata", 64'(HWDATA), 64'(e.data));
        dataPending = 1'b0;
      end else if (dataPending && latWr) begin
        checkOutput("stalled HWDATA", 64'(HWDATA), 64'(expQ[0].data));
      end
      if (HTRANS == 2'b10) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected transfer", 64'(HADDR), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          checkOutput("addr phase HADDR", 64'(HADDR), 64'(expQ[0].addr));
          checkOutput("addr phase HSEL", 64'(HSEL), 64'd1);
          if (HREADY) begin
            dataPending = 1'b1;
            latAddr     = HADDR;
            latWr       = HWRITE;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    HRESETn  = 1'b0;
    start    = 1'b0;
    tint     = 1'b0;
    HREADY   = 1'b1;
    HRESP    = 1'b0;
    HRDATA   = 32'h0;
    prescale = 32'h0;
    period   = 96'h0;
    chan_en  = 3'b000;
    repeat (3) tickCycle();
    checkOutput("reset HTRANS", 64'(HTRANS), 64'd0);
    checkOutput("reset HSEL", 64'(HSEL), 64'd0);
    checkOutput("reset HADDR", 64'(HADDR), 64'd0);
    checkOutput("reset HWRITE", 64'(HWRITE), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset error", 64'(error), 64'd0);
    checkOutput("reset tick", 64'(tick), 64'd0);
    HRESETn = 1'b1;
    repeat (2) tickCycle();

    $display("[TB] full init, three channels");
    expectWr(32'h00, 32'd4);
    expectWr(32'h1C, 32'd0); expectWr(32'h18, 32'd10);
    expectWr(32'h2C, 32'd0); expectWr(32'h28, 32'd20);
    expectWr(32'h3C, 32'd0); expectWr(32'h38, 32'd30);
    expectWr(32'h0C, 32'd7);
    applyStimulus(32'd4, {32'd30, 32'd20, 32'd10}, 3'b111);
    cycles = 0;
    while (busy && cycles < 200) begin
      tickCycle();
      cycles++;
    end
    checkOutput("init cycle count", 64'(cycles), 64'd16);
    drain("init", 50);

    $display("[TB] service channels 0 and 2");
    expectRd(32'h08);
    expectWr(32'h1C, 32'd0); expectWr(32'h18, 32'd20); expectTick(3'b001);
    expectWr(32'h3C, 32'd0); expectWr(32'h38, 32'd60); expectTick(3'b100);
    pulseTint(32'h5);
    drain("svc 0+2", 100);

    $display("[TB] wait states on channel 1 re-arm");
    expectRd(32'h08);
    expectWr(32'h2C, 32'd0); expectWr(32'h28, 32'd40); expectTick(3'b010);
    pulseTint(32'h2);
    waitAddr(32'h2C, "wait HI addr");
    HREADY = 1'b0;
    repeat (3) tickCycle();
    HREADY = 1'b1;
    tickCycle();
    HREADY = 1'b0;
    repeat (2) tickCycle();
    HREADY = 1'b1;
    drain("wait states", 100);

    $display("[TB] restart, 64-bit carry, zero period, ignored start");
    expectWr(32'h00, 32'd1);
    expectWr(32'h1C, 32'd0); expectWr(32'h18, 32'hFFFF_FFF0);
    expectWr(32'h2C, 32'd0); expectWr(32'h28, 32'd0);
    expectWr(32'h0C, 32'd3);
    applyStimulus(32'd1, {32'd7, 32'd0, 32'hFFFF_FFF0}, 3'b011);
    repeat (3) tickCycle();
    start = 1'b1;
    tickCycle();
    start = 1'b0;
    drain("restart", 100);
    expectRd(32'h08);
    expectWr(32'h1C, 32'd1); expectWr(32'h18, 32'hFFFF_FFE0); expectTick(3'b001);
    pulseTint(32'h3);
    drain("carry 1", 100);
    expectRd(32'h08);
    expectWr(32'h1C, 32'd2); expectWr(32'h18, 32'hFFFF_FFD0); expectTick(3'b001);
    pulseTint(32'h7);
    drain("carry 2", 100);
    expectRd(32'h08);
    pulseTint(32'h2);
    drain("spurious", 100);

    $display("[TB] HRESP error on IENABLE write");
    expectWr(32'h00, 32'd2);
    expectWr(32'h1C, 32'd0); expectWr(32'h18, 32'd5);
    expectWr(32'h0C, 32'd1);
    applyStimulus(32'd2, {32'd0, 32'd0, 32'd5}, 3'b001);
    waitAddr(32'h0C, "wait IENABLE");
    tickCycle();
    HRESP = 1'b1;
    tickCycle();
    HRESP = 1'b0;
    checkOutput("err flag", 64'(error), 64'd1);
    checkOutput("err busy", 64'(busy), 64'd0);
    checkOutput("err HTRANS", 64'(HTRANS), 64'd0);
    checkOutput("err queue", 64'(expQ.size()), 64'd0);
    pulseTint(32'h1);
    repeat (5) tickCycle();
    checkOutput("err sticky", 64'(error), 64'd1);
    expectWr(32'h00, 32'd2);
    expectWr(32'h1C, 32'd0); expectWr(32'h18, 32'd5);
    expectWr(32'h0C, 32'd1);
    applyStimulus(32'd2, {32'd0, 32'd0, 32'd5}, 3'b001);
    checkOutput("err cleared", 64'(error), 64'd0);
    drain("err rerun", 100);

    $display("[TB] reset during data phase");
    expectWr(32'h00, 32'd9);
    applyStimulus(32'd9, {32'd50, 32'd0, 32'd0}, 3'b100);
    tickCycle();
    HRESETn = 1'b0;
    #1;
    checkOutput("rst HTRANS", 64'(HTRANS), 64'd0);
    checkOutput("rst HWDATA", 64'(HWDATA), 64'd0);
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst tick", 64'(tick), 64'd0);
    expQ.delete();
    repeat (2) tickCycle();
    HRESETn = 1'b1;
    pulseTint(32'h4);
    repeat (4) tickCycle();
    checkOutput("post-rst busy", 64'(busy), 64'd0);
    checkOutput("post-rst HTRANS", 64'(HTRANS), 64'd0);
    expectWr(32'h00, 32'd9);
    expectWr(32'h3C, 32'd0); expectWr(32'h38, 32'd50);
    expectWr(32'h0C, 32'd4);
    applyStimulus(32'd9, {32'd50, 32'd0, 32'd0}, 3'b100);
    drain("post-rst init", 100);
    expectRd(32'h08);
    expectWr(32'h3C, 32'd0); expectWr(32'h38, 32'd100); expectTick(3'b100);
    pulseTint(32'h4);
    drain("post-rst svc", 100);

    repeat (3) tickCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
